// File: rtl/beeb_bus_target.sv
// beeb_bus_target: 6502-bus mailbox target with a 4-byte register window.
// The Phi2/addr/rnw/data bus is sampled in the fast clock domain. Each bus
// cycle is captured on the Phi2 rise and committed on the Phi2 fall.
// The window bridges to two byte FIFOs: host->local (tx) and local->host (rx).
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   phi2, addr, rnw     asynchronous bus control / address
//   data_in             bus write data
//   data_out, data_oe   bus read data and driver enable
//   irq_n               active-low interrupt (rx data available & irq_en)
//   tx_data/valid/ready host->local stream (first-word fall-through)
//   rx_data/valid/ready local->host stream

// Byte FIFO, first-word fall-through. The head reads 8'h00 when empty.
// A pop on a full FIFO frees space for a push on the same clock.
module beeb_bus_target_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module beeb_bus_target #(
  parameter logic [15:0] BASE_ADDR   = 16'hFCB0,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phi2,
  input  logic [15:0] addr,
  input  logic        rnw,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        irq_n,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic       phi2_s, phi2_d_q, rise, fall;
  logic [1:0] a_q, a_d;
  logic       rnw_q, rnw_d, sel_q, sel_d;
  logic [7:0] rd_q, rd_d, rd_mux, wd_q;
  logic       irq_en_q, irq_en_d, ovf_q, ovf_d, unf_q, unf_d, irq_n_q;

  logic       tx_push, tx_empty, tx_full;
  logic       rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;
  logic       rx_avail, tx_space;

  assign phi2_s = sync_q[SYNC_STAGES-1];
  assign rise   = phi2_s & ~phi2_d_q;
  assign fall   = ~phi2_s & phi2_d_q;

  assign rx_avail = ~rx_empty;
  assign tx_space = ~tx_full;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  assign data_out = rd_q;
  assign data_oe  = (state_q == ACTIVE) & sel_q & rnw_q & phi2_s;
  assign irq_n    = irq_n_q;

  // Register read value, sampled into rd_q on the rise clock.
  always_comb begin
    case (addr[1:0])
      2'd0:    rd_mux = {irq_en_q, 5'b0, tx_space, rx_avail};
      2'd1:    rd_mux = rx_head;
      2'd2:    rd_mux = {6'b0, unf_q, ovf_q};
      default: rd_mux = ID_VALUE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    rnw_d    = rnw_q;
    sel_d    = sel_q;
    rd_d     = rd_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACTIVE;
          a_d     = addr[1:0];
          rnw_d   = rnw;
          sel_d   = (addr[15:2] == BASE_ADDR[15:2]);
          rd_d    = rd_mux;
        end
      end
      ACTIVE: begin
        if (fall) begin
          state_d = IDLE;
          if (sel_q) begin
            if (rnw_q) begin
              if (a_q == 2'd1) begin
                if (rx_avail) rx_pop = 1'b1;
                else          unf_d  = 1'b1;
              end
            end else begin
              case (a_q)
                2'd0: irq_en_d = wd_q[7];
                2'd1: begin
                  // A full tx FIFO still accepts the byte if the consumer
                  // pops on this same clock.
                  if (tx_full && !tx_ready) ovf_d   = 1'b1;
                  else                      tx_push = 1'b1;
                end
                2'd2: begin
                  ovf_d = 1'b0;
                  unf_d = 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Reset to 1 so that a release with phi2 high gives no false rise.
      sync_q   <= '1;
      phi2_d_q <= 1'b1;
      state_q  <= IDLE;
      a_q      <= '0;
      rnw_q    <= 1'b1;
      sel_q    <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], phi2};
      phi2_d_q <= phi2_s;
      state_q  <= state_d;
      a_q      <= a_d;
      rnw_q    <= rnw_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      if (phi2_s) wd_q <= data_in;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_n_q  <= ~(irq_en_q & rx_avail);
    end
  end

  beeb_bus_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (tx_push),
    .wdata_i (wd_q),
    .pop_i   (tx_ready),
    .rdata_o (tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  beeb_bus_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (rx_valid),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );
endmodule

// File: tb/tb_beeb_bus_target.sv
// Scoreboard bench for beeb_bus_target: bus reads and tx deliveries are
// queued as expectations and checked by a monitor when the DUT presents them.
module tb_beeb_bus_target;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned PHI2_HI = 4;
  localparam int unsigned PHI2_LO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        phi2 = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        rnw = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        irq_n;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] rd_exp[$];
  logic [7:0] tx_exp[$];
  logic       oe_prev = 1'b0;
  logic       oe_cut = 1'b0;
  int         oe_run = 0;

  beeb_bus_target #(
    .BASE_ADDR(16'hFCB0), .FIFO_DEPTH(16), .ID_VALUE(8'hA5), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock), .reset(reset), .phi2(phi2), .addr(addr), .rnw(rnw),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .irq_n(irq_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each falling edge.
  always @(negedge clock) begin
    #1;
    if (data_oe === 1'b1 && oe_prev !== 1'b1) begin
      if (rd_exp.size() == 0) chk("unexpected_oe", 8'h01, 8'h00);
      else chk("bus_read", data_out, rd_exp.pop_front());
      oe_run = 1;
    end else if (data_oe === 1'b1) begin
      oe_run++;
    end else if (oe_prev === 1'b1) begin
      if (!oe_cut) chk("oe_width", 8'(oe_run), 8'(PHI2_HI - 1));
      oe_cut = 1'b0;
    end
    oe_prev = data_oe;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_exp.size() == 0) chk("unexpected_tx", 8'h01, 8'h00);
      else chk("tx_data", tx_data, tx_exp.pop_front());
    end
  end

  task automatic bus_rise(input logic [15:0] a, input logic r, input logic [7:0] wd);
    @(negedge clock);
    addr = a; rnw = r; data_in = wd; phi2 = 1'b1;
    repeat (PHI2_HI) @(negedge clock);
  endtask

  task automatic bus_fall();
    phi2 = 1'b0;
    repeat (PHI2_LO) @(negedge clock);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] wd);
    bus_rise(a, 1'b0, wd);
    bus_fall();
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp);
    rd_exp.push_back(exp);
    bus_rise(a, 1'b1, 8'h00);
    bus_fall();
  endtask

  task automatic drain_tx();
    int n = 0;
    tx_ready = 1'b1;
    while (tx_valid && n < 64) begin
      @(negedge clock);
      n++;
    end
    chk("tx_drain", {7'b0, tx_valid}, 8'h00);
    @(negedge clock);
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with phi2 held high.
    repeat (4) @(negedge clock);
    chk("rst_oe", {7'b0, data_oe}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_irq_n", {7'b0, irq_n}, 8'h01);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    phi2 = 1'b0;                      // fall in IDLE, ignored
    repeat (6) @(negedge clock);
    bus_read(16'hFCB3, 8'hA5);
    chk("id_tx_untouched", {7'b0, tx_valid}, 8'h00);
    chk("id_rx_untouched", {7'b0, rx_ready}, 8'h01);

    // Three tx writes, consumer stalled, then drained in order.
    bus_write(16'hFCB1, 8'h11); tx_exp.push_back(8'h11);
    bus_write(16'hFCB1, 8'h22); tx_exp.push_back(8'h22);
    bus_write(16'hFCB1, 8'h33); tx_exp.push_back(8'h33);
    chk("tx_valid_held", {7'b0, tx_valid}, 8'h01);
    chk("tx_head_held", tx_data, 8'h11);
    drain_tx();

    // Overflow: 17th byte dropped.
    for (int i = 0; i < 17; i++) begin
      bus_write(16'hFCB1, 8'(8'h40 + i));
      if (i < 16) tx_exp.push_back(8'(8'h40 + i));
    end
    bus_read(16'hFCB2, 8'h01);
    bus_read(16'hFCB0, 8'h00);        // tx full: tx_space=0
    bus_write(16'hFCB2, 8'h00);
    bus_read(16'hFCB2, 8'h00);
    drain_tx();

    // Underflow on empty rx read.
    bus_read(16'hFCB1, 8'h00);
    bus_read(16'hFCB2, 8'h02);
    bus_write(16'hFCB2, 8'hFF);

    // rx push, then enable irq with exact latency.
    @(negedge clock);
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("irq_disabled", {7'b0, irq_n}, 8'h01);
    bus_rise(16'hFCB0, 1'b0, 8'h80);
    phi2 = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    chk("irq_pre", {7'b0, irq_n}, 8'h01);
    @(negedge clock);
    chk("irq_set", {7'b0, irq_n}, 8'h00);
    repeat (2) @(negedge clock);
    bus_read(16'hFCB0, 8'h83);

    // Pop rx; irq_n releases one clock after the pop.
    rd_exp.push_back(8'h5A);
    bus_rise(16'hFCB1, 1'b1, 8'h00);
    phi2 = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    chk("irq_hold", {7'b0, irq_n}, 8'h00);
    @(negedge clock);
    chk("irq_clr", {7'b0, irq_n}, 8'h01);
    repeat (2) @(negedge clock);

    // Non-decoded address: no drive, no state change.
    bus_read(16'hFCB4, 8'h00);
    void'(rd_exp.pop_back());         // no drive expected for FCB4
    bus_write(16'hFCB5, 8'h99);
    bus_read(16'hFCB2, 8'h00);
    bus_read(16'hFCB0, 8'h82);
    chk("nodecode_tx", {7'b0, tx_valid}, 8'h00);

    // Reset during an active FCB1 write: nothing pushed.
    bus_rise(16'hFCB1, 1'b0, 8'h77);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_wr_oe", {7'b0, data_oe}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    phi2 = 1'b0;
    repeat (8) @(negedge clock);
    chk("rst_wr_nopush", {7'b0, tx_valid}, 8'h00);

    // Reset during an active ID read: driver released on the next clock.
    oe_cut = 1'b1;
    rd_exp.push_back(8'hA5);
    bus_rise(16'hFCB3, 1'b1, 8'h00);
    chk("rd_active_oe", {7'b0, data_oe}, 8'h01);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_rd_oe", {7'b0, data_oe}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    phi2 = 1'b0;
    repeat (8) @(negedge clock);
    bus_read(16'hFCB0, 8'h02);        // irq_en cleared by reset

    repeat (4) @(negedge clock);
    chk("rd_queue_empty", 8'(rd_exp.size()), 8'h00);
    chk("tx_queue_empty", 8'(tx_exp.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/beeb_bus_target.md
Name: beeb_bus_target

Overview:
- 6502-bus responder: a memory-mapped mailbox that a Beeb-side bus master (CPU or accelerator) reads and writes across Phi2 cycles.
- Samples the asynchronous Phi2/Addr/RnW/Data bus in the fast `clock` domain and decodes a 4-byte window.
- Returns read data on the bus and commits writes at the end of each cycle.
- Bridges the bus to two local byte-stream FIFOs: host-to-local (tx) and local-to-host (rx).

Parameters:
- BASE_ADDR, 16'hFCB0: window base; must be 4-byte aligned; decode is addr[15:2]==BASE_ADDR[15:2].
- FIFO_DEPTH, 16: entries per FIFO; power of 2, range 2..256.
- ID_VALUE, 8'hA5: constant returned by the ID register.
- SYNC_STAGES, 2: synchroniser flops on phi2; range 2..4.

Ports:
- clock  in  1  system clock; frequency must be at least 8x the Phi2 frequency.
- reset  in  1  synchronous, active-high reset.
- phi2  in  1  bus Phi2, asynchronous to clock.
- addr  in  16  bus address, asynchronous.
- rnw  in  1  bus read/not-write, asynchronous.
- data_in  in  8  bus data input.
- data_out  out  8  bus read data.
- data_oe  out  1  enable for the bus data driver / level shifter.
- irq_n  out  1  interrupt request, active low.
- tx_data  out  8  tx FIFO head (first-word fall-through).
- tx_valid  out  1  tx FIFO non-empty.
- tx_ready  in  1  local consumer accepts tx_data when tx_valid&tx_ready.
- rx_data  in  8  local producer byte.
- rx_valid  in  1  local producer strobe.
- rx_ready  out  1  rx FIFO not full.

Behaviour:
- Synchroniser: phi2 passes through SYNC_STAGES flops to give phi2_s; phi2_d is phi2_s delayed one clock.
  - All synchroniser flops and phi2_d reset to 1, so reset released with phi2 high cannot produce a false rise.
  - rise = phi2_s & !phi2_d; fall = !phi2_s & phi2_d.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on rise. In the same clock, latch a_q=addr[1:0], rnw_q, sel_q=(addr[15:2]==BASE_ADDR[15:2]), and rd_q=register-mux value.
  - ACTIVE -> IDLE on fall. Commit side effects on this clock only if sel_q.
  - A fall seen in IDLE is ignored.
- Drive: data_oe=1 exactly while state==ACTIVE & sel_q & rnw_q & phi2_s.
  - data_out=rd_q, held stable for the whole cycle.
  - data_oe drops on the fall clock.
- Write data: wd_q<=data_in on every clock where phi2_s=1. The commit at fall uses wd_q, i.e. the last sample taken while phi2_s was high.
- Register map by a_q:
  - 0 STATUS.
    - Read: {irq_en,5'b0,tx_space,rx_avail}, where rx_avail=rx FIFO non-empty and tx_space=tx FIFO not full.
    - Write: irq_en<=wd_q[7]; other bits ignored.
  - 1 DATA.
    - Read: rx FIFO head. At fall, pop if non-empty; if empty, return 8'h00 and set underflow.
    - Write: push wd_q to the tx FIFO. If full, drop the byte and set overflow.
  - 2 FLAGS.
    - Read: {6'b0,underflow,overflow}.
    - Write (any value): clears both flags.
  - 3 ID.
    - Read: ID_VALUE.
    - Write: ignored.
- Read side effects are evaluated against FIFO state at the fall clock. rd_q was captured at rise, so a byte pushed between rise and fall is not returned.
- FIFO rules:
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; a count register runs 0..FIFO_DEPTH.
  - A push and a pop on the same clock both occur and the count is unchanged. On a full FIFO, a same-clock pop frees space for the push.
  - rx push occurs when rx_valid&rx_ready.
  - tx pop occurs when tx_valid&tx_ready.
- irq_n=!(irq_en & rx_avail), registered; 1 clock latency from a FIFO or irq_en change.
- Reset values:
  - state=IDLE; data_oe=0; data_out=8'h00; irq_n=1.
  - irq_en=0; overflow=0; underflow=0.
  - Both FIFOs empty, so tx_valid=0, tx_data=8'h00, rx_ready=1.
- Reset mid-cycle: data_oe drops on the reset clock, and the interrupted bus cycle commits nothing.
- Back-to-back bus cycles: the fall of one cycle and the rise of the next are separated by at least 2 clocks at the minimum clock ratio; no hazard.

Test Plan:
- Reset release with phi2=1, then fall, then a read of ID at FCB3 -> the first fall is ignored; the read returns data_out=8'hA5 with data_oe=1 only while phi2_s is high; FIFOs untouched.
- Host writes 8'h11, 8'h22, 8'h33 to FCB1 with tx_ready=0 -> tx_valid=1 and tx_data=8'h11. Raise tx_ready -> 11, 22, 33 are delivered in order, then tx_valid=0.
- Host writes 17 bytes to FCB1 (FIFO_DEPTH=16) with tx_ready=0 -> the 17th byte is dropped and FCB2 reads 8'h01. Write 8'h00 to FCB2 -> FCB2 then reads 8'h00.
- Read FCB1 with the rx FIFO empty -> returns 8'h00 and FCB2 reads 8'h02.
- Push 8'h5A on rx, then write 8'h80 to FCB0 -> irq_n=0 one clock after the irq_en commit, and FCB0 reads 8'h83.
- Read FCB1 -> returns 8'h5A, and irq_n returns to 1 one clock after the pop.
- Read of a non-decoded address FCB4 -> data_oe stays 0 and no state changes. Assert reset while a FCB1 write is ACTIVE -> no push, and data_oe=0 on the next clock.
